pio_in_debounce_irq: RTL and testbench
======================================

// Module: pio_in_debounce_irq
// PURPOSE
//   Parametrised Avalon-MM input PIO, successor to the fixed 4-bit switch port. Samples WIDTH
//   asynchronous board inputs (switches/keys/robot limit sensors) through a 2-flop synchronizer,
//   debounces each bit, latches edges per a mode parameter, and raises a maskable level IRQ.
//   Sits as an Avalon slave in the Qsys system next to the other PIO ports; the Nios reads it.
// PARAMETERS
//   WIDTH            4     number of input channels, 1..32
//   DEBOUNCE_CYCLES  16    consecutive stable clk cycles to accept a change; 0 = bypass debounce
//   EDGE_TYPE        0     0 = rising, 1 = falling, 2 = any edge sets edgecapture
// PORTS
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   address     in   2      register select
//   chipselect  in   1      slave select; qualifies write
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data; bits above WIDTH ignored
//   in_port     in   WIDTH  asynchronous external inputs
//   readdata    out  32     registered read data, zero-extended above WIDTH
//   irq         out  1      level interrupt, active high
// BEHAVIOUR
//   Register map (word offsets):
//     0 DATA     RO  debounced input value
//     1 RAW      RO  synchronizer output (undebounced), for diagnostics
//     2 IRQMASK  RW  per-channel interrupt enable
//     3 EDGECAP  RW1C per-channel edge latch; write 1 clears bit, write 0 no effect
//   Writes to 0/1 ignored. Write occurs on edge where chipselect=1 and write_n=0.
//   Read: readdata registered every clk from address (no chipselect needed), 1-cycle latency.
//   Reset (sync, dominant over everything): sync flops, debounced value, counters, IRQMASK,
//     EDGECAP, readdata all 0; irq = 0 the cycle after reset edge.
//   Synchronizer: s1 <= in_port, s2 <= s1. RAW = s2.
//   Debounce per bit, counter width $clog2(DEBOUNCE_CYCLES+1):
//     s2 == deb -> cnt <= 0.
//     s2 != deb, cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
//     s2 != deb, cnt == DEBOUNCE_CYCLES-1 -> deb <= s2, cnt <= 0.
//     Any glitch back to deb before acceptance restarts count from 0. Counter never wraps.
//     DEBOUNCE_CYCLES=0: deb <= s2 every cycle (no counter instantiated).
//   Latency: change at in_port set up before edge k -> deb updates at edge k+1+DEBOUNCE_CYCLES
//     (k+2 when bypassed); visible in readdata one edge later.
//   Edge capture: evaluated on the edge deb changes; bit set if change matches EDGE_TYPE.
//     Set and RW1C clear of same bit on same edge -> set wins (bit stays 1).
//     Edges are captured regardless of IRQMASK.
//   irq = |(EDGECAP & IRQMASK), combinational from flops (no added latency); deasserts the
//     cycle after the clearing write or mask write.
//   Reset mid-debounce: count lost, deb=0; an input held 1 re-qualifies from scratch and sets
//     EDGECAP (rising) after full latency.
// STRUCTURE
//   Package pio_in_pkg: register offset constants (ADDR_DATA..ADDR_EDGECAP), EDGE_RISING/
//     EDGE_FALLING/EDGE_ANY constants.
//   Sub-module pio_debounce_bit (one per channel via generate): sync pair, counter, deb output,
//     rise/fall strobes. Top holds register file, edge logic, read mux, irq.
// TESTING  (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless noted)
//   Reset: assert reset with in_port=4'hF -> readdata=0, irq=0; read RAW 2 cycles later = 0xF.
//   Stable step: in_port 0->4'h5 before edge 0, held -> DATA=0x5 from edge 5, readdata=0x5 at edge 6.
//   Glitch: bit0 high 3 cycles then low -> DATA stays 0, EDGECAP=0; 4-cycle pulse -> accepted.
//   IRQ: IRQMASK=0x2, bit1 rises -> EDGECAP=0x2, irq=1; write EDGECAP 0x2 -> irq=0 next cycle;
//     bit2 rising with mask 0x2 -> EDGECAP=0x4, irq stays 0.
//   Set/clear race: RW1C of bit0 on same edge bit0 debounced-rises -> EDGECAP bit0 remains 1.
//   EDGE_TYPE=1 and 2: falling only vs both edges set EDGECAP; DEBOUNCE_CYCLES=0: DATA follows
//     in_port after 2 edges.

Source files
------------

// File: rtl/pio_in_pkg.sv
// Purpose: shared constants for the parametrised input PIO (register offsets, edge modes).
// Latency: n/a (constants only).
// Backpressure: n/a.
package pio_in_pkg;

    // Avalon word offsets of the four registers
    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RAW     = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    // Edge-capture modes selected by the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pio_debounce_bit.sv
// Purpose: one input channel -- 2-flop synchronizer, per-bit debounce counter, edge strobes.
// Latency: input change seen before edge k reaches deb at edge k+1+DEBOUNCE_CYCLES (k+2 bypassed).
// Backpressure: none; free-running every clk.
// Ports: clk, reset (sync, active-high), in_async (raw board pin), raw (synchronized),
//        deb (debounced value), rise/fall (combinational strobes, high on the edge deb changes).
module pio_debounce_bit
    import pio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_async,
    output logic raw,
    output logic deb,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic deb_q, deb_d;

    always_comb begin
        s1_d = in_async;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            deb_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            deb_q <= deb_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb deb_d = s2_q;
        end else begin : g_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Counter only runs while the synchronized input disagrees with the
            // accepted value; any return to agreement restarts from zero, and
            // reaching the last count accepts the new value instead of wrapping.
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (s2_q != deb_q) begin
                    if (cnt_q == CNT_LAST) begin
                        deb_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign raw  = s2_q;
    assign deb  = deb_q;
    // Strobes come from next-state so edge capture lands on the same edge deb changes
    assign rise = deb_d & ~deb_q;
    assign fall = ~deb_d & deb_q;

endmodule

// File: rtl/pio_in_debounce_irq.sv
// Purpose: Avalon-MM input PIO with per-channel debounce, edge capture and maskable level IRQ.
// Latency: readdata registered, 1 cycle after address; irq combinational from register flops.
// Backpressure: none; slave never stalls (no waitrequest), reads and writes complete each cycle.
// Ports: clk, reset (sync, active-high), address[1:0], chipselect, write_n, writedata[31:0],
//        in_port[WIDTH-1:0] (async pins), readdata[31:0] (zero-extended), irq (active high).
module pio_in_debounce_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] raw_w, deb_w, rise_w, fall_w;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            pio_debounce_bit #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_bit (
                .clk     (clk),
                .reset   (reset),
                .in_async(in_port[gi]),
                .raw     (raw_w[gi]),
                .deb     (deb_w[gi]),
                .rise    (rise_w[gi]),
                .fall    (fall_w[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] rd_sel;

    // Bits of writedata above WIDTH are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    always_comb begin
        wr_en = chipselect & ~write_n;

        if (EDGE_TYPE == EDGE_FALLING) begin
            edge_set = fall_w;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_set = rise_w | fall_w;
        end else begin
            edge_set = rise_w;
        end

        irqmask_d = irqmask_q;
        if (wr_en && (address == ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end

        edge_clr = '0;
        if (wr_en && (address == ADDR_EDGECAP)) begin
            edge_clr = writedata[WIDTH-1:0];
        end
        // OR-ing the set after the clear makes a same-edge capture win over W1C
        edgecap_d = (edgecap_q & ~edge_clr) | edge_set;

        case (address)
            ADDR_DATA:    rd_sel = deb_w;
            ADDR_RAW:     rd_sel = raw_w;
            ADDR_IRQMASK: rd_sel = irqmask_q;
            default:      rd_sel = edgecap_q;
        endcase
        readdata_d = '0;
        readdata_d[WIDTH-1:0] = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_debounce_irq.sv
// Purpose: directed self-checking bench for pio_in_debounce_irq (main config plus
//          falling-edge, any-edge and bypassed-debounce instances on a shared bus).
// Latency/backpressure: inputs driven 1 time unit after rising edges, outputs sampled there too.
module tb_pio_in_debounce_irq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic [1:0]  address;
    logic [31:0] writedata;
    logic [3:0]  in_m, in_f, in_a, in_b;
    logic [31:0] rd_m, rd_f, rd_a, rd_b;
    logic        irq_m, irq_f, irq_a, irq_b;

    int n_assert = 0;
    int n_fail   = 0;

    pio_in_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_m (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_m),
        .readdata(rd_m), .irq(irq_m));

    pio_in_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_f),
        .readdata(rd_f), .irq(irq_f));

    pio_in_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a));

    pio_in_debounce_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b));

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] a);
        address = a;
        step(1);
    endtask

    initial begin
        reset      = 1'b1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd1;
        writedata  = '0;
        in_m = 4'hF; in_f = 4'h0; in_a = 4'h0; in_b = 4'h0;

        // Reset state
        step(3);
        chk("reset_rd_m", rd_m, 32'h0);
        chk("reset_irq_m", {31'b0, irq_m}, 32'h0);
        chk("reset_rd_b", rd_b, 32'h0);
        chk("reset_irq_fab", {29'b0, irq_f, irq_a, irq_b}, 32'h0);

        // RAW follows the synchronizer after reset release
        reset = 1'b0;
        step(3);
        chk("raw_after_reset", rd_m, 32'hF);

        // Reset mid-debounce: count is lost, input re-qualifies from scratch
        reset = 1'b1;
        step(2);
        reset   = 1'b0;
        address = 2'd0;
        step(6);
        chk("requal_not_yet", rd_m, 32'h0);
        step(1);
        chk("requal_data", rd_m, 32'hF);
        bus_read(2'd3);
        chk("requal_edgecap", rd_m, 32'hF);
        chk("requal_irq_masked", {31'b0, irq_m}, 32'h0);
        bus_write(2'd3, 32'hF);
        in_m = 4'h0;
        step(8);
        bus_read(2'd3);
        chk("clear_edgecap", rd_m, 32'h0);
        bus_read(2'd0);
        chk("fall_data", rd_m, 32'h0);

        // Stable step to 0x5
        address = 2'd0;
        in_m    = 4'h5;
        step(6);
        chk("step_edge5", rd_m, 32'h0);
        step(1);
        chk("step_edge6", rd_m, 32'h5);
        bus_read(2'd3);
        chk("step_edgecap", rd_m, 32'h5);
        bus_write(2'd3, 32'h5);
        in_m = 4'h0;
        step(8);
        bus_read(2'd3);
        chk("step_fall_no_cap", rd_m, 32'h0);

        // Glitch: 3-cycle pulse rejected, 4-cycle pulse accepted
        in_m = 4'h1;
        step(3);
        in_m = 4'h0;
        step(8);
        bus_read(2'd0);
        chk("glitch_data", rd_m, 32'h0);
        bus_read(2'd3);
        chk("glitch_edgecap", rd_m, 32'h0);
        in_m = 4'h1;
        step(4);
        in_m = 4'h0;
        step(2);
        bus_read(2'd0);
        chk("pulse4_data", rd_m, 32'h1);
        bus_read(2'd3);
        chk("pulse4_edgecap", rd_m, 32'h1);
        step(6);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        chk("pulse4_cleared", rd_m, 32'h0);

        // IRQ masking and clearing
        bus_write(2'd2, 32'h2);
        in_m = 4'h2;
        step(5);
        chk("irq_before_accept", {31'b0, irq_m}, 32'h0);
        step(1);
        chk("irq_on_accept", {31'b0, irq_m}, 32'h1);
        bus_read(2'd3);
        chk("irq_edgecap", rd_m, 32'h2);
        bus_write(2'd3, 32'h2);
        chk("irq_after_clear", {31'b0, irq_m}, 32'h0);
        in_m = 4'h6;
        step(8);
        bus_read(2'd3);
        chk("masked_edgecap", rd_m, 32'h4);
        chk("masked_irq", {31'b0, irq_m}, 32'h0);
        bus_read(2'd2);
        chk("irqmask_readback", rd_m, 32'h2);
        bus_write(2'd2, 32'h4);
        chk("irq_mask_enable", {31'b0, irq_m}, 32'h1);
        bus_write(2'd2, 32'h0);
        chk("irq_mask_disable", {31'b0, irq_m}, 32'h0);
        bus_write(2'd3, 32'hF);
        in_m = 4'h0;
        step(8);

        // Set/clear race on bit0: capture wins
        in_m = 4'h1;
        step(5);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        chk("race_set_wins", rd_m, 32'h1);
        bus_write(2'd3, 32'h1);
        bus_read(2'd3);
        chk("race_then_clear", rd_m, 32'h0);

        // Falling / any-edge / bypass instances
        address = 2'd0;
        in_f = 4'h3; in_a = 4'h3; in_b = 4'h3;
        step(3);
        chk("bypass_edge2", rd_b, 32'h0);
        step(1);
        chk("bypass_edge3", rd_b, 32'h3);
        step(4);
        bus_read(2'd3);
        chk("rise_f_nocap", rd_f, 32'h0);
        chk("rise_a_cap", rd_a, 32'h3);
        chk("rise_b_cap", rd_b, 32'h3);
        in_f = 4'h1; in_a = 4'h1; in_b = 4'h1;
        step(8);
        bus_read(2'd3);
        chk("fall1_f_cap", rd_f, 32'h2);
        chk("fall1_a_cap", rd_a, 32'h3);
        chk("fall1_b_cap", rd_b, 32'h3);
        bus_write(2'd3, 32'hF);
        in_f = 4'h0; in_a = 4'h0; in_b = 4'h0;
        step(8);
        bus_read(2'd3);
        chk("fall0_f_cap", rd_f, 32'h1);
        chk("fall0_a_cap", rd_a, 32'h1);
        chk("fall0_b_cap", rd_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
